// File: rtl/pipe_reg_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
// Per-boundary field widths, depth limit and the stage-operation decode.
package pipe_reg_pkg;

  localparam int DEPTH_MAX = 8;

  // Field widths for each pipeline boundary of the 5-stage core
  localparam int IF_ID_CTRL_W  = 1;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 9;
  localparam int ID_EX_DATA_W  = 111;
  localparam int EX_MEM_CTRL_W = 3;
  localparam int EX_MEM_DATA_W = 69;
  localparam int MEM_WB_CTRL_W = 2;
  localparam int MEM_WB_DATA_W = 69;

  typedef enum logic [1:0] {
    OP_LOAD,
    OP_HOLD,
    OP_KILL
  } cell_op_e;

  // Flush outranks stall; otherwise the chain advances
  function automatic cell_op_e cell_op(
    input logic stall,
    input logic flush
  );
    if (flush) return OP_KILL;
    if (stall) return OP_HOLD;
    return OP_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One stage of the pipeline register chain: {valid, ctrl, data}.
// Exactly one of load/hold/kill is expected to be high each cycle.
module pipe_stage_cell #(
  parameter int CTRL_W     = 3,
  parameter int DATA_W     = 69,
  parameter bit FLUSH_DATA = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_i,
  input  logic              hold_i,
  input  logic              kill_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    unique case (1'b1)
      kill_i: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        if (FLUSH_DATA) data_d = '0;
      end
      load_i: begin
        valid_d = valid_i;
        ctrl_d  = ctrl_i;
        data_d  = data_i;
      end
      hold_i: ;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Parametrised inter-stage register: DEPTH-deep delay line with
// stall/flush, valid-gated control output and saturating event counters.
module pipeline_stage_reg
  import pipe_reg_pkg::*;
#(
  parameter int CTRL_W     = EX_MEM_CTRL_W,
  parameter int DATA_W     = EX_MEM_DATA_W,
  parameter int DEPTH      = 1,
  parameter int CNT_W      = 16,
  parameter bit FLUSH_DATA = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              StallIn,
  input  logic              FlushIn,
  input  logic              CntClr,
  input  logic              ValidIn,
  input  logic [CTRL_W-1:0] CtrlIn,
  input  logic [DATA_W-1:0] DataIn,
  output logic              ValidOut,
  output logic [CTRL_W-1:0] CtrlOut,
  output logic [DATA_W-1:0] DataOut,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  generate
    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_depth_chk
      $error("pipeline_stage_reg: DEPTH must be 1..8");
    end
  endgenerate

  cell_op_e op;
  logic     load, hold, kill;

  assign op   = cell_op(StallIn, FlushIn);
  assign load = (op == OP_LOAD);
  assign hold = (op == OP_HOLD);
  assign kill = (op == OP_KILL);

  logic              valid_s [DEPTH+1];
  logic [CTRL_W-1:0] ctrl_s  [DEPTH+1];
  logic [DATA_W-1:0] data_s  [DEPTH+1];

  assign valid_s[0] = ValidIn;
  assign ctrl_s[0]  = CtrlIn;
  assign data_s[0]  = DataIn;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_stage_cell #(
      .CTRL_W    (CTRL_W),
      .DATA_W    (DATA_W),
      .FLUSH_DATA(FLUSH_DATA)
    ) u_cell (
      .CLK    (CLK),
      .RST    (RST),
      .load_i (load),
      .hold_i (hold),
      .kill_i (kill),
      .valid_i(valid_s[k]),
      .ctrl_i (ctrl_s[k]),
      .data_i (data_s[k]),
      .valid_o(valid_s[k+1]),
      .ctrl_o (ctrl_s[k+1]),
      .data_o (data_s[k+1])
    );
  end

  // A bubble must never leak RegWrite/MemWrite downstream
  assign ValidOut = valid_s[DEPTH];
  assign CtrlOut  = ValidOut ? ctrl_s[DEPTH] : '0;
  assign DataOut  = data_s[DEPTH];

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (CntClr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else if (StallIn && !FlushIn) begin
      if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (FlushIn) begin
      if (!(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: three configurations on shared stimulus,
// a transaction scoreboard on the DEPTH=3 copy plus directed checks.
module tb_pipeline_stage_reg;

  localparam int CW = 3;
  localparam int DW = 69;

  logic          CLK;
  logic          RST;
  logic          StallIn, FlushIn, CntClr, ValidIn;
  logic [CW-1:0] CtrlIn;
  logic [DW-1:0] DataIn;

  logic          v1, v3, v2;
  logic [CW-1:0] c1, c3, c2;
  logic [DW-1:0] d1, d3, d2;
  logic [15:0]   s1, f1, s2, f2;
  logic [3:0]    s3, f3;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } item_t;

  item_t sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  pipeline_stage_reg #(
    .CTRL_W(CW), .DATA_W(DW), .DEPTH(1), .CNT_W(16), .FLUSH_DATA(1'b0)
  ) u_d1 (
    .CLK(CLK), .RST(RST), .StallIn(StallIn), .FlushIn(FlushIn),
    .CntClr(CntClr), .ValidIn(ValidIn), .CtrlIn(CtrlIn), .DataIn(DataIn),
    .ValidOut(v1), .CtrlOut(c1), .DataOut(d1),
    .StallCnt(s1), .FlushCnt(f1)
  );

  pipeline_stage_reg #(
    .CTRL_W(CW), .DATA_W(DW), .DEPTH(3), .CNT_W(4), .FLUSH_DATA(1'b0)
  ) u_d3 (
    .CLK(CLK), .RST(RST), .StallIn(StallIn), .FlushIn(FlushIn),
    .CntClr(CntClr), .ValidIn(ValidIn), .CtrlIn(CtrlIn), .DataIn(DataIn),
    .ValidOut(v3), .CtrlOut(c3), .DataOut(d3),
    .StallCnt(s3), .FlushCnt(f3)
  );

  pipeline_stage_reg #(
    .CTRL_W(CW), .DATA_W(DW), .DEPTH(2), .CNT_W(16), .FLUSH_DATA(1'b1)
  ) u_d2 (
    .CLK(CLK), .RST(RST), .StallIn(StallIn), .FlushIn(FlushIn),
    .CntClr(CntClr), .ValidIn(ValidIn), .CtrlIn(CtrlIn), .DataIn(DataIn),
    .ValidOut(v2), .CtrlOut(c2), .DataOut(d2),
    .StallCnt(s2), .FlushCnt(f2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(
    input logic          v,
    input logic [CW-1:0] c,
    input logic [DW-1:0] d,
    input logic          st,
    input logic          fl,
    input logic          clr
  );
    ValidIn = v;
    CtrlIn  = c;
    DataIn  = d;
    StallIn = st;
    FlushIn = fl;
    CntClr  = clr;
    if (fl) sb_q.delete();
    else if (!st && v) sb_q.push_back('{ctrl: c, data: d});
  endtask

  task automatic tick();
    logic  adv;
    item_t e;
    adv = !StallIn && !FlushIn && RST;
    @(posedge CLK);
    #1;
    if (adv && v3) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_valid", v3, 0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_ctrl", c3, e.ctrl);
        chk("sb_data", d3, e.data);
      end
    end
  endtask

  initial begin
    RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_v1", v1, 0);
    chk("rst_c1", c1, 0);
    chk("rst_d1", d1, 0);
    chk("rst_s1", s1, 0);
    chk("rst_f1", f1, 0);
    chk("rst_v3", v3, 0);
    RST = 1'b1;

    // reset/flow, DEPTH=1
    drive(1, 3'b101, 69'h1234, 0, 0, 0);
    chk("t1_pre_v", v1, 0);
    chk("t1_pre_d", d1, 0);
    tick();
    chk("t1_v", v1, 1);
    chk("t1_c", c1, 3'b101);
    chk("t1_d", d1, 69'h1234);

    drive(0, 3'b111, 69'h55, 0, 0, 0);
    tick();
    chk("bub_v", v1, 0);
    chk("bub_c", c1, 0);
    chk("bub_d", d1, 69'h55);
    repeat (3) begin
      drive(0, 0, 0, 0, 0, 0);
      tick();
    end

    // latency, DEPTH=3
    for (int i = 1; i <= 4; i++) begin
      drive(1, 3'(i), 69'(i), 0, 0, 0);
      tick();
      chk("lat_v", v3, (i >= 3));
      if (i >= 3) chk("lat_d", d3, i - 2);
    end

    // stall with changing input
    for (int k = 0; k < 2; k++) begin
      drive(1, 3'b011, 69'd99, 1, 0, 0);
      tick();
      chk("stl_v", v3, 1);
      chk("stl_d", d3, 2);
    end
    chk("stl_cnt3", s3, 2);
    chk("stl_cnt1", s1, 2);
    for (int i = 5; i <= 7; i++) begin
      drive(1, 3'(i), 69'(i), 0, 0, (i == 7));
      tick();
      chk("resume_d", d3, i - 2);
    end
    chk("clr_s3_pre", s3, 0);

    // flush + stall together, three valid items in flight
    drive(1, 3'b111, 69'd88, 1, 1, 0);
    tick();
    chk("fl_v3", v3, 0);
    chk("fl_c3", c3, 0);
    chk("fl_d3", d3, 5);
    chk("fl_f3", f3, 1);
    chk("fl_s3", s3, 0);
    chk("fl_v2", v2, 0);
    chk("fl_d2", d2, 0);
    repeat (3) begin
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk("fl_kill_v", v3, 0);
    end
    chk("sb_drain", sb_q.size(), 0);

    // saturation and clear, CNT_W=4
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      tick();
      chk("sat_s3", s3, (i < 15) ? i : 15);
    end
    chk("sat_s1", s1, 20);
    drive(0, 0, 0, 1, 0, 1);
    tick();
    chk("clr_s3", s3, 0);
    chk("clr_s1", s1, 0);
    chk("clr_f3", f3, 0);

    // async reset mid-stream, DEPTH=2
    drive(0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 3'b010, 69'hA, 0, 0, 0);
    tick();
    drive(1, 3'b100, 69'hB, 0, 0, 0);
    tick();
    chk("pre_v2", v2, 1);
    chk("pre_d2", d2, 69'hA);
    chk("pre_s2", s2, 1);
    chk("pre_f2", f2, 1);
    #3 RST = 1'b0;
    #1;
    chk("arst_v2", v2, 0);
    chk("arst_c2", c2, 0);
    chk("arst_d2", d2, 0);
    chk("arst_s2", s2, 0);
    chk("arst_f2", f2, 0);
    chk("arst_v1", v1, 0);
    sb_q.delete();
    drive(0, 0, 0, 0, 0, 0);
    #2 RST = 1'b1;
    tick();
    chk("post_v2", v2, 0);

    drive(1, 3'b110, 69'h77, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("post_v2b", v2, 1);
    chk("post_c2", c2, 3'b110);
    chk("post_d2", d2, 69'h77);
    repeat (2) begin
      drive(0, 0, 0, 0, 0, 0);
      tick();
    end
    chk("sb_final", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
